// File: rtl/melody_seq_if.sv
// Control and note-output bundle between top-level playback logic and melody_seq.
// Master drives start/stop/loop; slave (the sequencer) drives the note outputs.
interface melody_seq_if #(
  parameter int WIDTH_COUNTER = 10
);
  logic                     start;
  logic                     stop;
  logic                     loop;
  logic [WIDTH_COUNTER-1:0] half_period;
  logic                     tone_en;
  logic [2:0]               step_idx;
  logic                     busy;
  logic                     done;

  modport master (
    output start, stop, loop,
    input  half_period, tone_en, step_idx, busy, done
  );

  modport slave (
    input  start, stop, loop,
    output half_period, tone_en, step_idx, busy, done
  );
endinterface

// File: rtl/melody_seq.sv
// Steps an 8-entry song ROM, presenting half_period/tone_en per note with a silent gap between notes.
// Outputs registered; start shows on the sampling edge; no backpressure, stop wins over start.
module melody_seq #(
  parameter int BEAT_DIV      = 1000,
  parameter int GAP_TICKS     = 1,
  parameter int WIDTH_COUNTER = 10
) (
  input logic         clk,
  input logic         rst,
  melody_seq_if.slave ctl
);

  localparam int PW = $clog2(BEAT_DIV);
  localparam int GW = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_NOTE, S_GAP} state_t;

  // {note code[2:0], beats[1:0]}
  function automatic logic [4:0] song_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    return {3'd1, 2'd1};
      3'd1:    return {3'd1, 2'd1};
      3'd2:    return {3'd5, 2'd1};
      3'd3:    return {3'd5, 2'd1};
      3'd4:    return {3'd6, 2'd1};
      3'd5:    return {3'd6, 2'd1};
      3'd6:    return {3'd5, 2'd2};
      default: return {3'd0, 2'd1};
    endcase
  endfunction

  function automatic logic [WIDTH_COUNTER-1:0] note_hp(input logic [2:0] code);
    case (code)
      3'd1:    return WIDTH_COUNTER'(478);
      3'd2:    return WIDTH_COUNTER'(426);
      3'd3:    return WIDTH_COUNTER'(379);
      3'd4:    return WIDTH_COUNTER'(358);
      3'd5:    return WIDTH_COUNTER'(319);
      3'd6:    return WIDTH_COUNTER'(284);
      3'd7:    return WIDTH_COUNTER'(253);
      default: return '0;
    endcase
  endfunction

  state_t                   state_q, state_d;
  logic [2:0]               step_q, step_d;
  logic [1:0]               beat_q, beat_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic [WIDTH_COUNTER-1:0] hp_q, hp_d;
  logic                     tone_q, tone_d;
  logic                     done_q, done_d;
  logic                     busy_q;
  logic [PW-1:0]            presc_q, presc_d;
  logic                     tick;
  logic                     load_note;
  logic                     advance;
  logic [4:0]               entry;

  assign tick = (state_q != S_IDLE) && (presc_q == PW'(BEAT_DIV - 1));

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    hp_d      = hp_q;
    tone_d    = tone_q;
    done_d    = 1'b0;
    load_note = 1'b0;
    advance   = 1'b0;
    entry     = '0;

    case (state_q)
      S_IDLE: begin
        if (ctl.start) begin
          state_d   = S_NOTE;
          step_d    = '0;
          load_note = 1'b1;
        end
      end
      S_NOTE: begin
        if (tick) begin
          if (beat_q == 2'd1) begin
            if (GAP_TICKS > 0) begin
              state_d = S_GAP;
              gap_d   = GW'(GAP_TICKS);
              tone_d  = 1'b0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            beat_d = beat_q - 2'd1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == GW'(1)) advance = 1'b1;
          else                 gap_d   = gap_q - GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // loop is only looked at here, on the step-7 advance edge
    if (advance) begin
      if (step_q != 3'd7) begin
        step_d    = step_q + 3'd1;
        state_d   = S_NOTE;
        load_note = 1'b1;
      end else if (ctl.loop) begin
        step_d    = '0;
        state_d   = S_NOTE;
        load_note = 1'b1;
      end else begin
        state_d = S_IDLE;
        step_d  = '0;
        hp_d    = '0;
        tone_d  = 1'b0;
        done_d  = 1'b1;
      end
    end

    if (load_note) begin
      entry  = song_rom(step_d);
      beat_d = (entry[1:0] == 2'd0) ? 2'd1 : entry[1:0];
      hp_d   = note_hp(entry[4:2]);
      tone_d = (entry[4:2] != 3'd0);
    end

    if (ctl.stop) begin
      state_d = S_IDLE;
      step_d  = '0;
      hp_d    = '0;
      tone_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // Prescaler restarts from 0 whenever a song is launched out of IDLE
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (state_q == S_IDLE || state_d == S_IDLE || tick) presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
      hp_q    <= '0;
      tone_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      hp_q    <= hp_d;
      tone_q  <= tone_d;
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
      presc_q <= presc_d;
    end
  end

  assign ctl.half_period = hp_q;
  assign ctl.tone_en     = tone_q;
  assign ctl.step_idx    = step_q;
  assign ctl.busy        = busy_q;
  assign ctl.done        = done_q;

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: per-cycle comparison of all outputs against a song-timeline model,
// with randomized start offsets, stop points and loop-release points.
module tb_melody_seq;
  localparam int BD = 4;

  typedef logic [15:0] snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  int codes[8] = '{1, 1, 5, 5, 6, 6, 5, 0};
  int beats[8] = '{1, 1, 1, 1, 1, 1, 2, 1};
  int lut[8]   = '{0, 478, 426, 379, 358, 319, 284, 253};

  always #5 clk = ~clk;

  melody_seq_if #(.WIDTH_COUNTER(10)) ifc ();
  melody_seq_if #(.WIDTH_COUNTER(10)) ifc0 ();

  melody_seq #(.BEAT_DIV(BD), .GAP_TICKS(1), .WIDTH_COUNTER(10)) dut (
    .clk(clk), .rst(rst), .ctl(ifc)
  );
  melody_seq #(.BEAT_DIV(BD), .GAP_TICKS(0), .WIDTH_COUNTER(10)) dut0 (
    .clk(clk), .rst(rst), .ctl(ifc0)
  );

  // {half_period, tone_en, step_idx, busy, done}
  snap_t o1, o0;
  assign o1 = {ifc.half_period, ifc.tone_en, ifc.step_idx, ifc.busy, ifc.done};
  assign o0 = {ifc0.half_period, ifc0.tone_en, ifc0.step_idx, ifc0.busy, ifc0.done};

  function automatic int song_len(input int g);
    return (9 + 8 * g) * BD;
  endfunction

  // Expected outputs t cycles after the start edge of a single non-looping song
  function automatic snap_t base(input int t, input int g);
    int    acc;
    int    dn;
    int    gp;
    snap_t r;
    acc = 0;
    r   = '0;
    for (int s = 0; s < 8; s++) begin
      dn = BD * beats[s];
      gp = BD * g;
      if (t >= acc && t < acc + dn)
        r = {10'(lut[codes[s]]), (codes[s] != 0), 3'(s), 1'b1, 1'b0};
      acc += dn;
      if (t >= acc && t < acc + gp)
        r = {10'(lut[codes[s]]), 1'b0, 3'(s), 1'b1, 1'b0};
      acc += gp;
    end
    if (t == acc) r = 16'h0001;
    return r;
  endfunction

  // passes = number of complete passes played with loop held high before the final one
  function automatic snap_t model(input int t, input int passes, input int g);
    int n;
    n = song_len(g);
    if (t < passes * n) return base(t % n, g);
    return base(t - passes * n, g);
  endfunction

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.start = (i == 2);
      step_clk();
      checks++;
      if (o1 !== 16'h0000) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, o1, 16'h0000);
      end
    end
    rst = 1'b0;
    ifc.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step_clk();
      checks++;
      if (o1 !== 16'h0000) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, o1, 16'h0000);
      end
    end
  endtask

  task automatic test_full_song();
    int ign;
    ign = 23 + int'($urandom_range(7, 0));
    ifc.loop = 1'b0;
    idle_wait(int'($urandom_range(5, 0)));
    ifc.start = 1'b1;
    step_clk();
    ifc.start = 1'b0;
    for (int t = 0; t <= 70; t++) begin
      checks++;
      if (o1 !== model(t, 0, 1)) begin
        errors++;
        $display("FAIL full_song t=%0d got=%h exp=%h", t, o1, model(t, 0, 1));
      end
      ifc.start = (t == ign);
      step_clk();
    end
    ifc.start = 1'b0;
  endtask

  task automatic test_loop();
    int drop;
    int last;
    drop = 3 * 68 + 40 + int'($urandom_range(7, 0));
    last = 4 * 68 + 3;
    ifc.loop = 1'b1;
    idle_wait(int'($urandom_range(3, 0)));
    ifc.start = 1'b1;
    step_clk();
    ifc.start = 1'b0;
    for (int t = 0; t <= last; t++) begin
      checks++;
      if (o1 !== model(t, 3, 1)) begin
        errors++;
        $display("FAIL loop t=%0d got=%h exp=%h", t, o1, model(t, 3, 1));
      end
      if (t == drop) ifc.loop = 1'b0;
      step_clk();
    end
    ifc.loop = 1'b0;
  endtask

  task automatic test_stop();
    int ts;
    for (int it = 0; it < 6; it++) begin
      ts = (it == 0) ? 33 : int'($urandom_range(67, 0));
      idle_wait(int'($urandom_range(3, 0)));
      ifc.start = 1'b1;
      step_clk();
      ifc.start = 1'b0;
      for (int t = 0; t <= ts; t++) begin
        checks++;
        if (o1 !== model(t, 0, 1)) begin
          errors++;
          $display("FAIL stop_run it=%0d t=%0d got=%h exp=%h", it, t, o1, model(t, 0, 1));
        end
        if (t < ts) step_clk();
      end
      ifc.stop = 1'b1;
      step_clk();
      ifc.stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (o1 !== 16'h0000) begin
          errors++;
          $display("FAIL stop_idle it=%0d ts=%0d cyc=%0d got=%h exp=%h", it, ts, i, o1, 16'h0000);
        end
        step_clk();
      end
    end
  endtask

  task automatic test_start_stop_same();
    ifc.start = 1'b1;
    ifc.stop  = 1'b1;
    step_clk();
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o1 !== 16'h0000) begin
        errors++;
        $display("FAIL start_stop_same cyc=%0d got=%h exp=%h", i, o1, 16'h0000);
      end
      step_clk();
    end
  endtask

  task automatic test_gap0();
    idle_wait(int'($urandom_range(3, 0)));
    ifc0.start = 1'b1;
    step_clk();
    ifc0.start = 1'b0;
    for (int t = 0; t <= 40; t++) begin
      checks++;
      if (o0 !== model(t, 0, 0)) begin
        errors++;
        $display("FAIL gap0 t=%0d got=%h exp=%h", t, o0, model(t, 0, 0));
      end
      step_clk();
    end
  endtask

  initial begin
    ifc.start  = 1'b0;
    ifc.stop   = 1'b0;
    ifc.loop   = 1'b0;
    ifc0.start = 1'b0;
    ifc0.stop  = 1'b0;
    ifc0.loop  = 1'b0;
    test_reset();
    test_full_song();
    test_loop();
    test_stop();
    test_start_stop_same();
    test_full_song();
    test_gap0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/melody_seq.md
# melody_seq

Upstream note sequencer for the tone generator path. Plays a fixed internal song table one step at a time. For each step it presents a half-period divisor and a tone enable that the downstream programmable square-wave generator consumes. A silent gap separates consecutive notes. Start, stop and loop controls let top-level logic trigger, abort or repeat playback.

## Interface
Parameters:
- BEAT_DIV, default 1000: clk cycles per beat tick, ≥2.
- GAP_TICKS, default 1: beat ticks of silence after each note; 0 means no gap.
- WIDTH_COUNTER, default 10: width of half_period; must be ≥10.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin playback from step 0.
- stop  in  1  abort playback.
- loop  in  1  level; when 1, wrap from the last step back to step 0.
- half_period  out  WIDTH_COUNTER  clk cycles per half tone period for the current note; 0 for a rest.
- tone_en  out  1  high while a non-rest note sounds. The consumer holds its output low and its counter cleared while tone_en=0.
- step_idx  out  3  current step, 0..7.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a non-looping song completes.

## Operation
- Song table, fixed combinational ROM of 8 steps, given as {note code, beats}:
  - 0: {1,1}
  - 1: {1,1}
  - 2: {5,1}
  - 3: {5,1}
  - 4: {6,1}
  - 5: {6,1}
  - 6: {5,2}
  - 7: {0,1}
  - A beats value of 0 is treated as 1.
- Note code to half_period mapping: 0→0 (rest), 1→478, 2→426, 3→379, 4→358, 5→319, 6→284, 7→253.
- Beat prescaler runs 0..BEAT_DIV-1 while busy. tick = (prescaler==BEAT_DIV-1). The prescaler is held at 0 in IDLE and cleared when NOTE is entered from IDLE.
- State IDLE:
  - Outputs: busy=0, tone_en=0, half_period=0, step_idx=0.
  - start (without stop) → NOTE at step 0.
- State NOTE:
  - On entry, load beat_cnt=beats, half_period=lookup(code), tone_en=(code≠0).
  - Each tick decrements beat_cnt.
  - A tick with beat_cnt==1 moves to GAP if GAP_TICKS>0, otherwise to ADVANCE.
- State GAP:
  - tone_en=0; half_period holds its previous value.
  - Lasts GAP_TICKS ticks, then goes to ADVANCE.
- ADVANCE is the same-edge transition, not a separate state:
  - step_idx<7: step_idx+1, enter NOTE.
  - step_idx==7 and loop=1: step_idx=0, enter NOTE, no done pulse.
  - step_idx==7 and loop=0: IDLE, done=1 for one cycle.
- loop is sampled only at the ADVANCE edge of step 7.
- stop, in any state: next edge goes to IDLE with IDLE outputs and no done pulse.
- Simultaneous start and stop: stop wins.
- start while busy is ignored.
- rst overrides everything. Reset values: all outputs 0, state IDLE, prescaler 0.

## Timing
- All outputs are registered.
- start sampled at edge E: at E, busy=1, step_idx=0, half_period=478 and tone_en=1.
- A step with duration d occupies d·BEAT_DIV cycles of NOTE plus GAP_TICKS·BEAT_DIV cycles of GAP.
- half_period, step_idx and tone_en change only on the same edge, at step boundaries.
- Full non-looping song: (9 + 8·GAP_TICKS)·BEAT_DIV cycles from E to the edge where busy falls.
  - done rises on that same edge and is high for exactly one cycle.
- Loop wrap: step 7's GAP ends and step 0's NOTE begins on the same edge, with no idle cycle between them.
- stop sampled at edge S: outputs take IDLE values at S.

## Test plan
All scenarios use BEAT_DIV=4, GAP_TICKS=1.
- Reset: hold rst 3 cycles → all outputs 0, busy=0. Pulse start during rst → still IDLE after rst drops.
- Full song, loop=0: pulse start → sequence of (half_period, tone_en) per 4-cycle slot is (478,1), (478,0), (478,1), (478,0), (319,1)…
  - Step 6 gives 8 cycles of (319,1).
  - Step 7 gives 8 cycles of tone_en=0 with half_period=0.
  - busy drops and done pulses exactly 68 cycles after busy rose.
- Loop: loop=1, start → after step 7's gap, step_idx=0 and half_period=478 on the next edge. done never asserts across 3 full passes.
- Stop mid-note: stop during step 4, cycle 2 → next edge busy=0, tone_en=0, half_period=0, step_idx=0, no done. A subsequent start replays from step 0 at 478.
- Control corner cases:
  - start pulsed during step 3 → ignored, timing unchanged.
  - start and stop in the same cycle from IDLE → remains IDLE.
  - loop deasserted during step 5 of a looping pass → song ends after step 7 with done.
- GAP_TICKS=0 build: notes are back-to-back, tone_en stays 1 across steps 0→1 (half_period constant 478), and total song length is 36 cycles.
